// File: rtl/serial_rx_pkg.sv
// Shared definitions for the serial receive path: oversampling ratio,
// default frame length and the receive front-end state encoding.
package serial_rx_pkg;

  // Must match the input width of the downstream majority voter.
  localparam int SAMPLES_PER_BIT        = 8;
  localparam int DEFAULT_BITS_PER_FRAME = 10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COLLECT   = 2'd1,
    WAIT_IDLE = 2'd2
  } rx_state_e;

  function automatic logic is_falling(input logic prev, input logic cur);
    return prev & ~cur;
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-tick divider: one tick every CLKS_PER_SAMPLE clocks, with a
// half-period phase load used to centre sampling on a detected edge.
module sample_tick_gen #(
  parameter int CLKS_PER_SAMPLE = 13
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic load_half,
  output logic tick
);

  localparam int CW = (CLKS_PER_SAMPLE > 2) ? $clog2(CLKS_PER_SAMPLE) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_SAMPLE - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_SAMPLE / 2);
  // The load cycle itself counts as HALF, so the register takes the value after it.
  localparam logic [CW-1:0] LOAD_VAL = (HALF == LAST) ? {CW{1'b0}} : CW'(CLKS_PER_SAMPLE / 2 + 1);

  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;

  // Next count and tick strobe
  always_comb begin
    tick        = 1'b0;
    count_nxt_s = count_r;
    if (load_half) begin
      tick        = (HALF == LAST);
      count_nxt_s = LOAD_VAL;
    end else if (clear) begin
      count_nxt_s = {CW{1'b0}};
    end else if (count_r == LAST) begin
      tick        = 1'b1;
      count_nxt_s = {CW{1'b0}};
    end else begin
      count_nxt_s = count_r + CW'(1);
    end
  end

  // Divider count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CW{1'b0}};
    end else begin
      count_r <= count_nxt_s;
    end
  end

endmodule

// File: rtl/oversample_window.sv
// Receive front end: synchronises rx_in, aligns to the start-bit falling edge
// and emits one 8-sample window per bit with start/stop position flags.
module oversample_window
  import serial_rx_pkg::*;
#(
  parameter int CLKS_PER_SAMPLE = 13,
  parameter int BITS_PER_FRAME  = DEFAULT_BITS_PER_FRAME,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       rx_in,
  input  logic       abort,
  output logic [7:0] window,
  output logic       window_valid,
  output logic       window_first,
  output logic       window_last,
  output logic       busy
);

  localparam int SPB = SAMPLES_PER_BIT;
  localparam int IW  = $clog2(SPB);
  localparam logic [IW-1:0] LAST_SAMPLE = IW'(SPB - 1);
  localparam logic [3:0]    LAST_BIT    = 4'(BITS_PER_FRAME - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;
  logic                   rx_sync_s;
  logic                   start_s;
  logic                   tick_s;
  logic [SPB-1:0]         shift_s;

  rx_state_e              state_r;
  logic [SPB-1:0]         shreg_r;
  logic [IW-1:0]          sample_idx_r;
  logic [3:0]             bit_idx_r;
  logic [7:0]             window_r;
  logic                   valid_r;
  logic                   first_r;
  logic                   last_r;
  logic                   busy_r;

  assign rx_sync_s = sync_r[SYNC_STAGES-1];
  assign start_s   = (state_r == IDLE) && en && is_falling(prev_r, rx_sync_s);
  assign shift_s   = {rx_sync_s, shreg_r[SPB-1:1]};

  // Line synchroniser and previous-sample flop, both idle-high out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{1'b1}};
      prev_r <= 1'b1;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], rx_in};
      prev_r <= rx_sync_s;
    end
  end

  sample_tick_gen #(
    .CLKS_PER_SAMPLE(CLKS_PER_SAMPLE)
  ) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state_r != COLLECT),
    .load_half(start_s),
    .tick     (tick_s)
  );

  // Frame FSM with registered window, strobe and frame-position outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      shreg_r      <= {SPB{1'b0}};
      sample_idx_r <= {IW{1'b0}};
      bit_idx_r    <= 4'd0;
      window_r     <= 8'h00;
      valid_r      <= 1'b0;
      first_r      <= 1'b0;
      last_r       <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      first_r <= 1'b0;
      last_r  <= 1'b0;
      if (!en) begin
        state_r <= IDLE;
        busy_r  <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (start_s) begin
              state_r   <= COLLECT;
              busy_r    <= 1'b1;
              bit_idx_r <= 4'd0;
              // Very short sample periods put the first tick on the start cycle itself.
              if (tick_s) begin
                shreg_r      <= {rx_sync_s, {(SPB-1){1'b0}}};
                sample_idx_r <= IW'(1);
              end else begin
                shreg_r      <= {SPB{1'b0}};
                sample_idx_r <= {IW{1'b0}};
              end
            end else begin
              busy_r <= 1'b0;
            end
          end
          COLLECT: begin
            if (valid_r && abort) begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end else if (valid_r && last_r) begin
              if (rx_sync_s) begin
                state_r <= IDLE;
                busy_r  <= 1'b0;
              end else begin
                state_r <= WAIT_IDLE;
                busy_r  <= 1'b1;
              end
            end else begin
              if (valid_r) begin
                bit_idx_r <= bit_idx_r + 4'd1;
              end
              if (tick_s) begin
                shreg_r      <= shift_s;
                sample_idx_r <= sample_idx_r + IW'(1);
                if (sample_idx_r == LAST_SAMPLE) begin
                  window_r <= shift_s;
                  valid_r  <= 1'b1;
                  first_r  <= (bit_idx_r == 4'd0);
                  last_r   <= (bit_idx_r == LAST_BIT);
                end
              end
            end
          end
          WAIT_IDLE: begin
            if (rx_sync_s) begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end
          end
          default: begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign window       = window_r;
  assign window_valid = valid_r;
  assign window_first = first_r;
  assign window_last  = last_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_oversample_window.sv
// Self-checking bench for oversample_window with a time-arithmetic reference model.
module tb_oversample_window;

  localparam int CPS       = 4;
  localparam int BPF       = 10;
  localparam int SYNC      = 2;
  localparam int BITCLK    = 8 * CPS;
  localparam int FIRST_OFF = CPS - 1 - CPS / 2;
  localparam int VALID_OFF = FIRST_OFF + 7 * CPS + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       rx_in;
  logic       abort;
  logic [7:0] window;
  logic       window_valid, window_first, window_last, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  oversample_window #(.CLKS_PER_SAMPLE(CPS), .BITS_PER_FRAME(BPF), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rx_in(rx_in), .abort(abort),
    .window(window), .window_valid(window_valid), .window_first(window_first),
    .window_last(window_last), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: line delay, then start time T; bit k's window holds the line
  // at T+FIRST_OFF+BITCLK*k+CPS*j and is presented at T+VALID_OFF+BITCLK*k.
  logic       m_s0, m_s1, m_prev, m_valid, m_first, m_last;
  logic [7:0] m_win;
  logic [1:0] m_mode;
  int         m_t0;
  logic       hist [0:32767];

  function automatic logic rs_at(input int idx);
    if (idx == cyc) return m_s1;
    else return hist[15'(idx)];
  endfunction

  function automatic logic [7:0] model_window(input int t0, input int k);
    logic [7:0] w;
    for (int j = 0; j < 8; j++) w[j] = rs_at(t0 + FIRST_OFF + BITCLK * k + CPS * j);
    return w;
  endfunction

  function automatic int bit_num(input int t0);
    return (cyc - t0 - (VALID_OFF - 1)) / BITCLK;
  endfunction

  function automatic logic valid_due(input int t0);
    int e;
    e = cyc - t0 - (VALID_OFF - 1);
    return (e >= 0) && (e % BITCLK == 0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s0 <= 1'b1; m_s1 <= 1'b1; m_prev <= 1'b1;
      m_valid <= 1'b0; m_first <= 1'b0; m_last <= 1'b0;
      m_win <= 8'h00; m_mode <= 2'd0; m_t0 <= 0;
    end else begin
      m_s0 <= rx_in; m_s1 <= m_s0; m_prev <= m_s1;
      hist[15'(cyc)] <= m_s1;
      m_valid <= 1'b0; m_first <= 1'b0; m_last <= 1'b0;
      if (!en) m_mode <= 2'd0;
      else if (m_mode == 2'd0) begin
        if (m_prev && !m_s1) begin m_mode <= 2'd1; m_t0 <= cyc; end
      end else if (m_mode == 2'd1) begin
        if (m_valid && abort) m_mode <= 2'd0;
        else if (m_valid && m_last) m_mode <= m_s1 ? 2'd0 : 2'd2;
        else if (valid_due(m_t0)) begin
          m_valid <= 1'b1;
          m_win   <= model_window(m_t0, bit_num(m_t0));
          m_first <= (bit_num(m_t0) == 0);
          m_last  <= (bit_num(m_t0) == BPF - 1);
        end
      end else if (m_s1) m_mode <= 2'd0;
    end
  end

  wire [11:0] dut_vec = {window, window_valid, window_first, window_last, busy};
  wire [11:0] ref_vec = {m_win, m_valid, m_first, m_last, (m_mode != 2'd0)};

  logic       wave [$];
  int         vq_cyc [$];
  logic [7:0] vq_win [$];
  logic [1:0] vq_flg [$];

  task automatic push_level(input logic v, input int n);
    for (int i = 0; i < n; i++) wave.push_back(v);
  endtask

  task automatic push_frame(input logic [7:0] d);
    push_level(1'b0, BITCLK);
    for (int b = 0; b < 8; b++) push_level(d[b], BITCLK);
    push_level(1'b1, BITCLK);
  endtask

  task automatic clear_log();
    wave.delete(); vq_cyc.delete(); vq_win.delete(); vq_flg.delete();
  endtask

  // Drive one line level for one clock and log any window strobe.
  task automatic step(input logic rx);
    rx_in = rx;
    @(posedge clk); #1;
    abort = 1'b0;
    if (window_valid) begin
      vq_cyc.push_back(cyc); vq_win.push_back(window); vq_flg.push_back({window_first, window_last});
    end
  endtask

  function automatic logic [7:0] bit_window(input logic [7:0] d, input int k);
    if (k == 0) return 8'h00;
    else if (k == BPF - 1) return 8'hFF;
    else return d[k-1] ? 8'hFF : 8'h00;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; rx_in = 1'b1; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dut_vec !== 12'h000) begin errors++; $display("FAIL reset_state got=%h exp=000", dut_vec); end
    rst_n = 1'b1;
    for (int i = 0; i < 500; i++) begin
      step(1'b1);
      checks++;
      if (dut_vec !== 12'h000) begin errors++; $display("FAIL reset_idle cyc=%0d got=%h exp=000", cyc, dut_vec); end
    end
  endtask

  task automatic test_clean_frame(input logic [7:0] d);
    int gap, c0, t;
    clear_log();
    gap = $urandom_range(3, 40);
    push_level(1'b1, gap); push_frame(d); push_level(1'b1, 40);
    c0 = cyc; t = c0 + gap + SYNC;
    for (int i = 0; i < wave.size(); i++) begin
      step(wave[i]);
      checks++;
      if (dut_vec !== ref_vec) begin errors++; $display("FAIL frame_model cyc=%0d got=%h exp=%h", cyc, dut_vec, ref_vec); end
      if (cyc == t + BITCLK * BPF - 1) begin
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL frame_busy_end got=%b exp=0", busy); end
      end
    end
    checks++;
    if (vq_cyc.size() != BPF) begin errors++; $display("FAIL frame_count data=%h got=%0d exp=%0d", d, vq_cyc.size(), BPF); end
    for (int k = 0; k < vq_cyc.size() && k < BPF; k++) begin
      checks++;
      if (vq_cyc[k] != t + VALID_OFF + BITCLK * k || vq_win[k] !== bit_window(d, k) ||
          vq_flg[k] !== {(k == 0), (k == BPF - 1)})
      begin
        errors++;
        $display("FAIL frame_window k=%0d got=%0d/%h/%b exp=%0d/%h/%b", k, vq_cyc[k], vq_win[k], vq_flg[k],
                 t + VALID_OFF + BITCLK * k, bit_window(d, k), {(k == 0), (k == BPF - 1)});
      end
    end
  endtask

  task automatic test_glitch(input int len);
    int c0, t;
    logic [7:0] ew;
    clear_log();
    push_level(1'b1, 10); push_level(1'b0, len); push_level(1'b1, 150);
    c0 = cyc; t = c0 + 10 + SYNC;
    for (int j = 0; j < 8; j++) ew[j] = (CPS * j + FIRST_OFF >= len);
    for (int i = 0; i < wave.size(); i++) begin
      step(wave[i]);
      checks++;
      if (dut_vec !== ref_vec) begin errors++; $display("FAIL glitch_model cyc=%0d got=%h exp=%h", cyc, dut_vec, ref_vec); end
      if (cyc == t + VALID_OFF + 1) begin
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL glitch_abort_busy got=%b exp=0", busy); end
      end
      if (window_valid) abort = 1'b1;
    end
    checks++;
    if (vq_cyc.size() != 1 || vq_cyc[0] != t + VALID_OFF || vq_win[0] !== ew) begin
      errors++;
      $display("FAIL glitch_window len=%0d got_n=%0d got=%h exp=%h", len, vq_cyc.size(),
               (vq_win.size() > 0) ? vq_win[0] : 8'hxx, ew);
    end
    test_clean_frame(8'h55);
  endtask

  task automatic test_break();
    int c0, t, t2, h;
    logic [7:0] d;
    clear_log();
    h = $urandom_range(1, 3); d = 8'($urandom);
    push_level(1'b1, 10); push_level(1'b0, 400); push_level(1'b1, h); push_frame(d); push_level(1'b1, 40);
    c0 = cyc; t = c0 + 10 + SYNC; t2 = c0 + 410 + h + SYNC;
    for (int i = 0; i < wave.size(); i++) begin
      step(wave[i]);
      checks++;
      if (dut_vec !== ref_vec) begin errors++; $display("FAIL break_model cyc=%0d got=%h exp=%h", cyc, dut_vec, ref_vec); end
      if (cyc == t + 330 || cyc == t + 397) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL break_wait_busy cyc=%0d got=%b exp=1", cyc, busy); end
      end
    end
    checks++;
    if (vq_cyc.size() != 2 * BPF) begin errors++; $display("FAIL break_count got=%0d exp=%0d", vq_cyc.size(), 2 * BPF); end
    for (int k = 0; k < vq_cyc.size() && k < 2 * BPF; k++) begin
      checks++;
      if (k < BPF ? (vq_win[k] !== 8'h00 || vq_cyc[k] != t + VALID_OFF + BITCLK * k)
                  : (vq_win[k] !== bit_window(d, k - BPF) || vq_cyc[k] != t2 + VALID_OFF + BITCLK * (k - BPF)))
      begin
        errors++;
        $display("FAIL break_window k=%0d got=%0d/%h", k, vq_cyc[k], vq_win[k]);
      end
    end
  endtask

  task automatic test_en_drop();
    int drop_cyc;
    logic [7:0] a3_exp [BPF];
    a3_exp = '{8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'hFF};
    clear_log();
    drop_cyc = -10;
    push_level(1'b1, $urandom_range(3, 20)); push_frame(8'($urandom)); push_level(1'b1, 40);
    for (int i = 0; i < wave.size(); i++) begin
      step(wave[i]);
      checks++;
      if (dut_vec !== ref_vec) begin errors++; $display("FAIL en_model cyc=%0d got=%h exp=%h", cyc, dut_vec, ref_vec); end
      if (cyc == drop_cyc + 1) begin
        checks++;
        if (busy !== 1'b0 || window_valid !== 1'b0) begin
          errors++; $display("FAIL en_drop busy/valid got=%b%b exp=00", busy, window_valid);
        end
      end
      if (window_valid && vq_cyc.size() == 5 && en) begin en = 1'b0; drop_cyc = cyc; end
    end
    checks++;
    if (vq_cyc.size() != 5) begin errors++; $display("FAIL en_low_windows got=%0d exp=5", vq_cyc.size()); end
    en = 1'b1;
    clear_log();
    push_level(1'b1, 20); push_frame(8'hA3); push_level(1'b1, 40);
    for (int i = 0; i < wave.size(); i++) begin
      step(wave[i]);
      checks++;
      if (dut_vec !== ref_vec) begin errors++; $display("FAIL en_a3_model cyc=%0d got=%h exp=%h", cyc, dut_vec, ref_vec); end
    end
    checks++;
    if (vq_cyc.size() != BPF) begin errors++; $display("FAIL en_a3_count got=%0d exp=%0d", vq_cyc.size(), BPF); end
    for (int k = 0; k < vq_win.size() && k < BPF; k++) begin
      checks++;
      if (vq_win[k] !== a3_exp[k]) begin errors++; $display("FAIL en_a3_window k=%0d got=%h exp=%h", k, vq_win[k], a3_exp[k]); end
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    push_level(1'b1, 10); push_frame(8'($urandom)); push_level(1'b1, 40);
    for (int i = 0; i < wave.size(); i++) begin
      step(wave[i]);
      checks++;
      if (dut_vec !== ref_vec) begin errors++; $display("FAIL rstmid_model cyc=%0d got=%h exp=%h", cyc, dut_vec, ref_vec); end
      if (vq_cyc.size() == 3) break;
    end
    rx_in = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dut_vec !== 12'h000) begin errors++; $display("FAIL rstmid_async got=%h exp=000", dut_vec); end
    repeat (3) step(1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step(1'b1);
      checks++;
      if (window_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL rstmid_quiet cyc=%0d got=%b%b exp=00", cyc, window_valid, busy);
      end
    end
    test_clean_frame(8'($urandom));
  endtask

  initial begin
    test_reset();
    test_clean_frame(8'h55);
    for (int n = 0; n < 3; n++) test_clean_frame(8'($urandom));
    test_glitch(8);
    test_glitch($urandom_range(1, 24));
    test_break();
    test_en_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
